ls_arbiter: RTL and testbench

LS_ARBITER -- requirements
Module: ls_arbiter

---
 rtl/spu_pkg.sv | 21 ++
 rtl/ls_starve_ctr.sv | 38 +++
 rtl/ls_arbiter.sv | 159 +++++++++++++++
 tb/tb_ls_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_pkg.sv
// Shared types and default sizing for the local-store arbiter slice.
package spu_pkg;

  localparam int LS_ADDR_W_DEF    = 11;
  localparam int QW_W_DEF         = 128;
  localparam int BURST_LEN_DEF    = 8;
  localparam int STARVE_LIMIT_DEF = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    RQ_NONE = 2'd0,
    RQ_DMA  = 2'd1,
    RQ_LSU  = 2'd2,
    RQ_IFU  = 2'd3
  } req_id_e;

endpackage

// File: rtl/ls_starve_ctr.sv
// Counts consecutive cycles the IFU waits ungranted, saturating at STARVE_LIMIT.
// starved_o is registered state only, so it never loops back through the grant logic.
module ls_starve_ctr
  import spu_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic ifu_req_i,
  input  logic ifu_gnt_i,
  output logic starved_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!ifu_req_i || ifu_gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(STARVE_LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starved_o = (cnt_q == CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/ls_arbiter.sv
// Local-store arbiter: DMA bursts, LSU and IFU share one single-port memory; grant is
// combinational from req, read data/rvalid follow one cycle after the grant, no queuing.
module ls_arbiter
  import spu_pkg::*;
#(
  parameter int LS_ADDR_W    = LS_ADDR_W_DEF,
  parameter int QW_W         = QW_W_DEF,
  parameter int BURST_LEN    = BURST_LEN_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dma_req,
  input  logic                 dma_we,
  input  logic [LS_ADDR_W-1:0] dma_addr,
  input  logic [QW_W-1:0]      dma_wdata,
  output logic                 dma_gnt,
  output logic                 dma_rvalid,
  input  logic                 lsu_req,
  input  logic                 lsu_we,
  input  logic [LS_ADDR_W-1:0] lsu_addr,
  input  logic [QW_W-1:0]      lsu_wdata,
  output logic                 lsu_gnt,
  output logic                 lsu_rvalid,
  input  logic                 ifu_req,
  input  logic [LS_ADDR_W-1:0] ifu_addr,
  output logic                 ifu_gnt,
  output logic                 ifu_rvalid,
  output logic                 ifu_stall,
  output logic [QW_W-1:0]      rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [LS_ADDR_W-1:0] mem_addr,
  output logic [QW_W-1:0]      mem_wdata,
  input  logic [QW_W-1:0]      mem_rdata
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  arb_state_e           state_q, state_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [LS_ADDR_W-1:0] base_q, base_d;
  logic                 bwe_q, bwe_d;
  logic                 rv_dma_q, rv_dma_d;
  logic                 rv_lsu_q, rv_lsu_d;
  logic                 rv_ifu_q, rv_ifu_d;
  req_id_e              win;
  logic                 starved;

  ls_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .ifu_req_i (ifu_req),
    .ifu_gnt_i (ifu_gnt),
    .starved_o (starved)
  );

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    base_d    = base_q;
    bwe_d     = bwe_q;
    win       = RQ_NONE;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    // Reset low masks every grant even though the inputs may still be requesting.
    if (!reset) begin
      win = RQ_NONE;
    end else if (state_q == ST_BURST) begin
      win       = RQ_DMA;
      mem_en    = 1'b1;
      mem_we    = bwe_q;
      mem_addr  = base_q + LS_ADDR_W'(beat_q);
      mem_wdata = dma_wdata;
      if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end else begin
      if (starved && ifu_req) begin
        win = RQ_IFU;
      end else if (dma_req) begin
        win = RQ_DMA;
      end else if (lsu_req) begin
        win = RQ_LSU;
      end else if (ifu_req) begin
        win = RQ_IFU;
      end

      case (win)
        RQ_DMA: begin
          mem_en    = 1'b1;
          mem_we    = dma_we;
          mem_addr  = dma_addr;
          mem_wdata = dma_wdata;
          base_d    = dma_addr;
          bwe_d     = dma_we;
          if (BURST_LEN > 1) begin
            state_d = ST_BURST;
            beat_d  = BEAT_W'(1);
          end
        end
        RQ_LSU: begin
          mem_en    = 1'b1;
          mem_we    = lsu_we;
          mem_addr  = lsu_addr;
          mem_wdata = lsu_wdata;
        end
        RQ_IFU: begin
          mem_en   = 1'b1;
          mem_addr = ifu_addr;
        end
        default: ;
      endcase
    end

    rv_dma_d = (win == RQ_DMA) && !mem_we;
    rv_lsu_d = (win == RQ_LSU) && !mem_we;
    rv_ifu_d = (win == RQ_IFU);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      base_q   <= '0;
      bwe_q    <= 1'b0;
      rv_dma_q <= 1'b0;
      rv_lsu_q <= 1'b0;
      rv_ifu_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      base_q   <= base_d;
      bwe_q    <= bwe_d;
      rv_dma_q <= rv_dma_d;
      rv_lsu_q <= rv_lsu_d;
      rv_ifu_q <= rv_ifu_d;
    end
  end

  assign dma_gnt    = (win == RQ_DMA);
  assign lsu_gnt    = (win == RQ_LSU);
  assign ifu_gnt    = (win == RQ_IFU);
  assign ifu_stall  = ifu_req & ~ifu_gnt;
  assign dma_rvalid = rv_dma_q;
  assign lsu_rvalid = rv_lsu_q;
  assign ifu_rvalid = rv_ifu_q;
  // The memory already delays read data by one cycle, lining it up with rvalid.
  assign rdata      = mem_rdata;

endmodule

// File: tb/tb_ls_arbiter.sv
// Directed scenarios plus random traffic, every cycle checked against a transaction-level model.
module tb_ls_arbiter;

  localparam int AW = 11;
  localparam int DW = 128;
  localparam int BL = 8;
  localparam int SL = 16;
  localparam int DEPTH = 2048;

  logic          clk = 1'b0;
  logic          reset;
  logic          dma_req, dma_we, lsu_req, lsu_we, ifu_req;
  logic [AW-1:0] dma_addr, lsu_addr, ifu_addr;
  logic [DW-1:0] dma_wdata, lsu_wdata, mem_rdata;
  logic          dma_gnt, dma_rvalid, lsu_gnt, lsu_rvalid, ifu_gnt, ifu_rvalid, ifu_stall;
  logic [DW-1:0] rdata, mem_wdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  ls_arbiter #(
    .LS_ADDR_W(AW), .QW_W(DW), .BURST_LEN(BL), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .reset(reset),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt), .ifu_rvalid(ifu_rvalid),
    .ifu_stall(ifu_stall), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  int n_chk = 0;
  int n_err = 0;

  // Environment memory (driven by the DUT's requests) and the model's own view of memory.
  logic [DW-1:0] env_mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  // Model state: beats still owed by the current burst, wait cycles of the IFU.
  int            m_left, m_beat, m_wait;
  logic [AW-1:0] m_base;
  logic          m_we;
  logic          e_rv_d, e_rv_l, e_rv_i;
  logic [DW-1:0] e_rdata;

  // Per-cycle captures for scenario checks.
  logic          c_dg, c_lg, c_ig, c_stall, c_en, c_we, c_rvl;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_and_model();
    int            w;
    logic [AW-1:0] ea;
    logic          ewe;
    logic [DW-1:0] ewd;
    w = 0; ea = '0; ewe = 1'b0; ewd = '0;
    if (!reset) begin
      w = 0;
    end else if (m_left > 0) begin
      w = 1; ea = AW'((int'(m_base) + m_beat) % DEPTH); ewe = m_we; ewd = dma_wdata;
    end else if (ifu_req && m_wait >= SL) begin
      w = 3; ea = ifu_addr;
    end else if (dma_req) begin
      w = 1; ea = dma_addr; ewe = dma_we; ewd = dma_wdata;
    end else if (lsu_req) begin
      w = 2; ea = lsu_addr; ewe = lsu_we; ewd = lsu_wdata;
    end else if (ifu_req) begin
      w = 3; ea = ifu_addr;
    end

    chk("dma_gnt", DW'(dma_gnt), DW'(w == 1));
    chk("lsu_gnt", DW'(lsu_gnt), DW'(w == 2));
    chk("ifu_gnt", DW'(ifu_gnt), DW'(w == 3));
    chk("onehot", DW'($countones({dma_gnt, lsu_gnt, ifu_gnt}) <= 1), DW'(1));
    chk("ifu_stall", DW'(ifu_stall), DW'(reset ? (ifu_req && w != 3) : ifu_req));
    chk("mem_en", DW'(mem_en), DW'(w != 0));
    if (w != 0) begin
      chk("mem_we", DW'(mem_we), DW'(ewe));
      chk("mem_addr", DW'(mem_addr), DW'(ea));
      if (ewe) chk("mem_wdata", mem_wdata, ewd);
    end
    chk("dma_rvalid", DW'(dma_rvalid), DW'(reset && e_rv_d));
    chk("lsu_rvalid", DW'(lsu_rvalid), DW'(reset && e_rv_l));
    chk("ifu_rvalid", DW'(ifu_rvalid), DW'(reset && e_rv_i));
    if (reset && (e_rv_d || e_rv_l || e_rv_i)) chk("rdata", rdata, e_rdata);

    c_dg = dma_gnt; c_lg = lsu_gnt; c_ig = ifu_gnt; c_stall = ifu_stall;
    c_en = mem_en; c_we = mem_we; c_addr = mem_addr; c_wdata = mem_wdata;
    c_rvl = lsu_rvalid; c_rdata = rdata;

    if (!reset) begin
      m_left = 0; m_beat = 0; m_wait = 0;
      e_rv_d = 1'b0; e_rv_l = 1'b0; e_rv_i = 1'b0;
    end else begin
      e_rv_d = (w == 1) && !ewe;
      e_rv_l = (w == 2) && !ewe;
      e_rv_i = (w == 3);
      e_rdata = ref_mem[ea];
      if (w != 0 && ewe) ref_mem[ea] = ewd;
      if (m_left > 0) begin
        m_beat++; m_left--;
      end else if (w == 1) begin
        m_base = dma_addr; m_we = dma_we; m_beat = 1; m_left = BL - 1;
      end
      if (ifu_req && w != 3) m_wait = (m_wait + 1 > SL) ? SL : m_wait + 1;
      else m_wait = 0;
    end
  endtask

  // Entered at posedge+1 with inputs set; leaves at the next posedge+1 with memory updated.
  task automatic cycle();
    #3;
    check_and_model();
    @(posedge clk);
    #1;
    if (c_en && c_we) env_mem[c_addr] = c_wdata;
    else if (c_en) mem_rdata = env_mem[c_addr];
    else mem_rdata = {4{$urandom}};
  endtask

  task automatic idle_inputs();
    dma_req = 1'b0; lsu_req = 1'b0; ifu_req = 1'b0;
    dma_we = 1'b0; lsu_we = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] exp_a [BL];
    int gd, gl, gi, stall_n;
    bit got;

    for (int i = 0; i < DEPTH; i++) begin
      env_mem[i] = {4{32'(i) * 32'h9E37_79B1}};
      ref_mem[i] = env_mem[i];
    end
    m_left = 0; m_beat = 0; m_wait = 0; m_base = '0; m_we = 1'b0;
    e_rv_d = 1'b0; e_rv_l = 1'b0; e_rv_i = 1'b0; e_rdata = '0;
    mem_rdata = '0;
    dma_addr = '0; lsu_addr = '0; ifu_addr = '0; dma_wdata = '0; lsu_wdata = '0;

    // Reset held with every requester active: nothing may be granted.
    reset = 1'b0;
    dma_req = 1'b1; lsu_req = 1'b1; ifu_req = 1'b1; dma_we = 1'b0; lsu_we = 1'b0;
    @(posedge clk); #1;
    cycle(); cycle();
    reset = 1'b1;
    idle_inputs();
    cycle();

    // Scenario 1: LSU read of a known quadword.
    env_mem[11'h010] = {16{8'hA5}};
    ref_mem[11'h010] = {16{8'hA5}};
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 11'h010;
    cycle();
    chk("s1_lsu_gnt", DW'(c_lg), DW'(1));
    idle_inputs();
    cycle();
    chk("s1_rvalid", DW'(c_rvl), DW'(1));
    chk("s1_rdata", c_rdata, {16{8'hA5}});

    // Scenario 2: all three request at once.
    dma_req = 1'b1; lsu_req = 1'b1; ifu_req = 1'b1;
    dma_addr = 11'h100; lsu_addr = 11'h200; ifu_addr = 11'h300;
    gd = -1; gl = -1; gi = -1;
    for (int k = 0; k < 20 && gi < 0; k++) begin
      cycle();
      if (c_dg && gd < 0) begin gd = k; dma_req = 1'b0; end
      if (c_lg) begin gl = k; lsu_req = 1'b0; end
      if (c_ig) begin gi = k; ifu_req = 1'b0; end
    end
    chk("s2_dma_cycle", DW'(gd), DW'(0));
    chk("s2_lsu_cycle", DW'(gl), DW'(BL));
    chk("s2_ifu_cycle", DW'(gi), DW'(BL + 1));
    idle_inputs();
    cycle();

    // Scenario 3: write burst wrapping past the top of the store; DMA drops req after beat 0.
    exp_a = '{11'h7FC, 11'h7FD, 11'h7FE, 11'h7FF, 11'h000, 11'h001, 11'h002, 11'h003};
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 11'h7FC;
    lsu_req = 1'b1; lsu_we = 1'b0; ifu_req = 1'b1;
    for (int k = 0; k < BL; k++) begin
      dma_wdata = {4{$urandom}};
      cycle();
      chk("s3_addr", DW'(c_addr), DW'(exp_a[k]));
      chk("s3_dma_only", DW'({c_dg, c_lg, c_ig}), DW'(3'b100));
      dma_req = 1'b0;
    end
    idle_inputs();
    cycle();

    // Scenario 4: DMA and LSU saturate while IFU waits.
    dma_req = 1'b1; dma_we = 1'b0; lsu_req = 1'b1; ifu_req = 1'b1;
    stall_n = 0; got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      dma_addr = AW'($urandom); lsu_addr = AW'($urandom); ifu_addr = AW'($urandom);
      cycle();
      if (c_ig) got = 1'b1;
      else if (c_stall) stall_n++;
    end
    chk("s4_ifu_granted", DW'(got), DW'(1));
    chk("s4_stall_cycles", DW'(stall_n), DW'(SL));
    chk("s4_dma_lost", DW'(c_dg), DW'(0));
    idle_inputs();
    cycle();

    // Scenario 5: reset arrives at beat 3 of a read burst.
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 11'h040;
    cycle(); dma_req = 1'b0;
    cycle(); cycle();
    #1;
    chk("s5_beat3_live", DW'(dma_gnt), DW'(1));
    reset = 1'b0;
    #1;
    chk("s5_gnt_off", DW'(dma_gnt), DW'(0));
    chk("s5_mem_en_off", DW'(mem_en), DW'(0));
    chk("s5_rvalid_off", DW'(dma_rvalid), DW'(0));
    cycle(); cycle();
    reset = 1'b1;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 11'h055;
    cycle();
    chk("s5_lsu_after", DW'(c_lg), DW'(1));
    idle_inputs();
    cycle();

    // Random traffic with occasional resets.
    for (int k = 0; k < 800; k++) begin
      reset     = ($urandom_range(0, 150) != 0);
      dma_req   = ($urandom_range(0, 3) == 0);
      lsu_req   = ($urandom_range(0, 1) == 1);
      ifu_req   = ($urandom_range(0, 3) != 0);
      dma_we    = ($urandom_range(0, 1) == 1);
      lsu_we    = ($urandom_range(0, 1) == 1);
      dma_addr  = AW'($urandom);
      lsu_addr  = AW'($urandom);
      ifu_addr  = AW'($urandom);
      dma_wdata = {4{$urandom}};
      lsu_wdata = {4{$urandom}};
      cycle();
    end
    reset = 1'b1;
    idle_inputs();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
